// File: rtl/w_grf.sv
// Writeback stage and 32x32 general register file for the five-stage MIPS core.
// Selects the W-stage write, commits it on the rising edge, bypasses it to the D-stage reads.
module w_grf (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] w_instr,
   input  logic [31:0] w_pc,
   input  logic [31:0] w_alu,
   input  logic [31:0] w_dm,
   input  logic        w_ovr_valid,
   input  logic [4:0]  w_ovr_addr,
   input  logic        w_kill,
   input  logic [4:0]  ra1,
   input  logic [4:0]  ra2,
   output logic [31:0] rd1,
   output logic [31:0] rd2,
   output logic        wb_we,
   output logic [4:0]  wb_addr,
   output logic [31:0] wb_data,
   output logic [31:0] instret
);

   localparam logic [5:0] OP_SPECIAL = 6'h00;
   localparam logic [5:0] OP_JAL     = 6'h03;
   localparam logic [5:0] OP_ORI     = 6'h0d;
   localparam logic [5:0] OP_LUI     = 6'h0f;
   localparam logic [5:0] OP_LW      = 6'h23;
   localparam logic [5:0] FN_ADDU    = 6'h21;
   localparam logic [5:0] FN_SUBU    = 6'h23;

   logic [5:0]  op;
   logic [5:0]  funct;
   logic [4:0]  rt;
   logic [4:0]  rd;
   logic        writes;
   logic [4:0]  dst;
   logic [31:0] src;
   logic        unused_instr_bits;

   logic [31:0] regs_q [0:31];
   logic [31:0] regs_d [0:31];
   logic [31:0] instret_q;
   logic [31:0] instret_d;

   assign op    = w_instr[31:26];
   assign funct = w_instr[5:0];
   assign rt    = w_instr[20:16];
   assign rd    = w_instr[15:11];
   assign unused_instr_bits = ^{w_instr[25:21], w_instr[10:6]};

   always_comb begin
      writes = 1'b0;
      dst    = 5'd0;
      src    = 32'd0;
      case (op)
         OP_SPECIAL: begin
            if (funct == FN_ADDU || funct == FN_SUBU) begin
               writes = 1'b1;
               dst    = rd;
               src    = w_alu;
            end
         end
         OP_ORI, OP_LUI: begin
            writes = 1'b1;
            dst    = rt;
            src    = w_alu;
         end
         OP_LW: begin
            writes = 1'b1;
            dst    = rt;
            src    = w_dm;
         end
         OP_JAL: begin
            writes = 1'b1;
            dst    = 5'd31;
            src    = w_pc + 32'd8;
         end
         default: ;
      endcase
      // The override retargets only instructions that actually write.
      if (writes && w_ovr_valid) begin
         dst = w_ovr_addr;
      end
   end

   always_comb begin
      wb_we   = writes && !w_kill && (dst != 5'd0);
      wb_addr = wb_we ? dst : 5'd0;
      wb_data = wb_we ? src : 32'd0;
   end

   // Stored values read as 0 while reset is held; the bypass stays live.
   function automatic logic [31:0] read_port(input logic [4:0] ra);
      logic [31:0] v;
      v = 32'd0;
      if (ra != 5'd0) begin
         if (wb_we && ra == wb_addr) begin
            v = wb_data;
         end else if (!reset) begin
            v = regs_q[ra];
         end
      end
      return v;
   endfunction

   always_comb begin
      rd1 = read_port(ra1);
      rd2 = read_port(ra2);
   end

   always_comb begin
      regs_d = regs_q;
      if (wb_we) begin
         regs_d[wb_addr] = wb_data;
      end
      instret_d = instret_q;
      if (w_instr != 32'd0 && !w_kill) begin
         instret_d = instret_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         regs_q    <= '{default: 32'd0};
         instret_q <= 32'd0;
      end else begin
         regs_q    <= regs_d;
         instret_q <= instret_d;
      end
   end

   assign instret = instret_q;

endmodule

// File: tb/tb_w_grf.sv
// Directed bench for w_grf: a register-file model checked every cycle plus literal spot checks.
module tb_w_grf;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] w_instr, w_pc, w_alu, w_dm;
   logic        w_ovr_valid, w_kill;
   logic [4:0]  w_ovr_addr, ra1, ra2;
   logic [31:0] rd1, rd2, wb_data, instret;
   logic        wb_we;
   logic [4:0]  wb_addr;

   int tests = 0;
   int fails = 0;
   bit chk_en = 1'b0;

   logic [31:0] model_rf [0:31];
   logic [31:0] model_instret;

   always #5 clk = ~clk;

   w_grf dut (
      .clk(clk), .reset(reset), .w_instr(w_instr), .w_pc(w_pc), .w_alu(w_alu), .w_dm(w_dm),
      .w_ovr_valid(w_ovr_valid), .w_ovr_addr(w_ovr_addr), .w_kill(w_kill),
      .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
      .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .instret(instret)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
      end
   endtask

   // What the current inputs must write, from the instruction table.
   task automatic expect_wb(output logic we, output logic [4:0] addr, output logic [31:0] data);
      logic [5:0] op; logic [5:0] fn; logic w; logic [4:0] d; logic [31:0] v;
      op = w_instr[31:26]; fn = w_instr[5:0];
      w = 1'b0; d = 5'd0; v = 32'd0;
      if (op == 6'h00 && (fn == 6'h21 || fn == 6'h23)) begin w = 1; d = w_instr[15:11]; v = w_alu; end
      if (op == 6'h0d || op == 6'h0f) begin w = 1; d = w_instr[20:16]; v = w_alu; end
      if (op == 6'h23) begin w = 1; d = w_instr[20:16]; v = w_dm; end
      if (op == 6'h03) begin w = 1; d = 5'd31; v = w_pc + 32'd8; end
      if (w && w_ovr_valid) d = w_ovr_addr;
      we = w && !w_kill && d != 0;
      addr = we ? d : 5'd0;
      data = we ? v : 32'd0;
   endtask

   function automatic logic [31:0] expect_rd(input logic [4:0] ra, input logic we,
                                             input logic [4:0] addr, input logic [31:0] data);
      if (ra == 0) return 32'd0;
      if (we && ra == addr) return data;
      if (reset) return 32'd0;
      return model_rf[ra];
   endfunction

   always @(posedge clk) begin
      logic we; logic [4:0] a; logic [31:0] d;
      expect_wb(we, a, d);
      if (reset) begin
         for (int i = 0; i < 32; i++) model_rf[i] = 32'd0;
         model_instret = 32'd0;
      end else begin
         if (we) model_rf[a] = d;
         if (w_instr != 0 && !w_kill) model_instret = model_instret + 32'd1;
      end
   end

   always @(negedge clk) begin
      logic we; logic [4:0] a; logic [31:0] d;
      if (chk_en) begin
         expect_wb(we, a, d);
         chk("wb_we", {31'd0, wb_we}, {31'd0, we});
         chk("wb_addr", {27'd0, wb_addr}, {27'd0, a});
         chk("wb_data", wb_data, d);
         chk("rd1", rd1, expect_rd(ra1, we, a, d));
         chk("rd2", rd2, expect_rd(ra2, we, a, d));
         chk("instret", instret, model_instret);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [31:0] instr, input logic [31:0] alu, input logic [31:0] dm,
                        input logic [4:0] r1, input logic [4:0] r2);
      w_instr = instr; w_alu = alu; w_dm = dm; ra1 = r1; ra2 = r2;
      w_pc = 32'd0; w_ovr_valid = 1'b0; w_ovr_addr = 5'd0; w_kill = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 32; i++) model_rf[i] = 32'd0;
      model_instret = 32'd0;
      reset = 1'b1;
      drive(32'd0, 32'd0, 32'd0, 5'd0, 5'd0);
      tick();
      chk_en = 1'b1;
      tick();
      reset = 1'b0;

      // Idle sweep of every register on both ports.
      for (int i = 0; i < 32; i++) begin
         drive(32'd0, 32'd0, 32'd0, 5'(i), 5'(31 - i));
         #1;
         chk("idle_rd1", rd1, 32'd0);
         chk("idle_rd2", rd2, 32'd0);
         tick();
      end
      chk("idle_instret", instret, 32'd0);
      chk("idle_we", {31'd0, wb_we}, 32'd0);

      // ori $5, 0x1234: bypass this cycle, stored next cycle.
      drive(32'h3405_1234, 32'h0000_1234, 32'd0, 5'd5, 5'd0);
      #1;
      chk("ori_bypass", rd1, 32'h0000_1234);
      chk("ori_we", {31'd0, wb_we}, 32'd1);
      chk("ori_addr", {27'd0, wb_addr}, 32'd5);
      tick();
      drive(32'd0, 32'd0, 32'd0, 5'd5, 5'd5);
      #1;
      chk("ori_stored", rd2, 32'h0000_1234);
      chk("ori_instret", instret, 32'd1);
      tick();

      // jal from 0x3010, then lw $8 with distinct ALU and load data.
      drive(32'h0C00_0123, 32'h1111_1111, 32'd0, 5'd0, 5'd0);
      w_pc = 32'h0000_3010;
      #1;
      chk("jal_data", wb_data, 32'h0000_3018);
      chk("jal_addr", {27'd0, wb_addr}, 32'd31);
      tick();
      drive(32'h8C08_0000, 32'h0000_0055, 32'hDEAD_BEEF, 5'd31, 5'd0);
      tick();
      drive(32'd0, 32'd0, 32'd0, 5'd31, 5'd8);
      #1;
      chk("jal_stored", rd1, 32'h0000_3018);
      chk("lw_stored", rd2, 32'hDEAD_BEEF);
      chk("instret_3", instret, 32'd3);
      tick();

      // addu into $0: no write, still retires.
      drive(32'h0022_0021, 32'hFFFF_FFFF, 32'd0, 5'd0, 5'd0);
      #1;
      chk("r0_we", {31'd0, wb_we}, 32'd0);
      chk("r0_rd", rd1, 32'd0);
      tick();
      chk("r0_instret", instret, 32'd4);

      // Killed addu $3: no write, no retire.
      drive(32'h0022_1821, 32'h0000_0033, 32'd0, 5'd3, 5'd0);
      w_kill = 1'b1;
      #1;
      chk("kill_we", {31'd0, wb_we}, 32'd0);
      tick();
      chk("kill_instret", instret, 32'd4);

      // lw $2 redirected to $7.
      drive(32'h8C02_0000, 32'h0000_0077, 32'hCAFE_F00D, 5'd7, 5'd2);
      w_ovr_valid = 1'b1; w_ovr_addr = 5'd7;
      tick();
      drive(32'd0, 32'd0, 32'd0, 5'd7, 5'd2);
      #1;
      chk("ovr_r7", rd1, 32'hCAFE_F00D);
      chk("ovr_r2", rd2, 32'd0);
      tick();

      // Back-to-back writes to $4, both ports on the write address.
      drive(32'h0022_2023, 32'h0000_0011, 32'd0, 5'd4, 5'd4);
      tick();
      drive(32'h3404_0099, 32'h0000_0099, 32'd0, 5'd4, 5'd4);
      #1;
      chk("b2b_rd1", rd1, 32'h0000_0099);
      chk("b2b_rd2", rd2, 32'h0000_0099);
      tick();
      drive(32'h3C04_ABCD, 32'hABCD_0000, 32'd0, 5'd4, 5'd4);
      tick();
      // Non-writing encodings with junk data, reading $4.
      drive(32'hAC04_0000, 32'h5555_5555, 32'h6666_6666, 5'd4, 5'd0); tick();
      drive(32'h1000_0004, 32'h5555_5555, 32'h6666_6666, 5'd4, 5'd0); tick();
      drive(32'h03E0_0008, 32'h5555_5555, 32'h6666_6666, 5'd4, 5'd31); tick();
      drive(32'hFC04_0000, 32'h5555_5555, 32'h6666_6666, 5'd4, 5'd0);
      #1;
      chk("lui_stored", rd1, 32'hABCD_0000);
      tick();

      // Reset during an ori $9 write discards it.
      drive(32'h3409_0042, 32'h0000_0042, 32'd0, 5'd9, 5'd5);
      reset = 1'b1;
      #1;
      chk("rst_stored_zero", rd2, 32'd0);
      tick();
      reset = 1'b0;
      drive(32'd0, 32'd0, 32'd0, 5'd9, 5'd31);
      #1;
      chk("rst_r9", rd1, 32'd0);
      chk("rst_instret", instret, 32'd0);
      tick();

      // Wrap: preload the counter just below 2^32.
      force dut.instret_q = 32'hFFFF_FFFE;
      model_instret = 32'hFFFF_FFFE;
      #1;
      release dut.instret_q;
      drive(32'hAC00_0000, 32'd0, 32'd0, 5'd0, 5'd0);
      tick();
      chk("wrap_max", instret, 32'hFFFF_FFFF);
      tick();
      chk("wrap_zero", instret, 32'd0);
      tick();
      chk("wrap_one", instret, 32'd1);
      drive(32'd0, 32'd0, 32'd0, 5'd0, 5'd0);
      tick();
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
